// File: rtl/jtoutrun_rdrom_srv_if.sv
// Road ROM server bus: two road client ports plus the SDRAM read port.
// master is the environment side, slave is the server.
interface jtoutrun_rdrom_srv_if #(
    parameter int AW = 14,
    parameter int DW = 16
);
    logic [AW-1:0] rom0_addr;
    logic          rom0_cs;
    logic [DW-1:0] rom0_data;
    logic          rom0_ok;
    logic [AW-1:0] rom1_addr;
    logic          rom1_cs;
    logic [DW-1:0] rom1_data;
    logic          rom1_ok;
    logic [AW-1:0] sdram_addr;
    logic          sdram_cs;
    logic [DW-1:0] sdram_data;
    logic          sdram_ok;

    modport master (
        output rom0_addr, rom0_cs, rom1_addr, rom1_cs,
        output sdram_data, sdram_ok,
        input  rom0_data, rom0_ok, rom1_data, rom1_ok,
        input  sdram_addr, sdram_cs
    );

    modport slave (
        input  rom0_addr, rom0_cs, rom1_addr, rom1_cs,
        input  sdram_data, sdram_ok,
        output rom0_data, rom0_ok, rom1_data, rom1_ok,
        output sdram_addr, sdram_cs
    );
endinterface

// File: rtl/jtoutrun_rdrom_srv.sv
// Road ROM server: one-entry cache per road port, shared SDRAM fetcher
// with alternating priority and shared-address fills.
module jtoutrun_rdrom_srv #(
    parameter int AW = 14,
    parameter int DW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    jtoutrun_rdrom_srv_if.slave   bus_io
);
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t        state_q, state_d;
    logic          pri_q, pri_d;
    logic          srv_q, srv_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] tag0_q, tag0_d, tag1_q, tag1_d;
    logic [DW-1:0] dat0_q, dat0_d, dat1_q, dat1_d;
    logic          vld0_q, vld0_d, vld1_q, vld1_d;

    logic hit0, hit1, miss0, miss1;
    logic take, fire, cs, sel, upd0, upd1;

    assign hit0  = vld0_q && (tag0_q == bus_io.rom0_addr);
    assign hit1  = vld1_q && (tag1_q == bus_io.rom1_addr);
    assign miss0 = bus_io.rom0_cs && !hit0;
    assign miss1 = bus_io.rom1_cs && !hit1;

    assign bus_io.rom0_ok    = bus_io.rom0_cs && hit0;
    assign bus_io.rom1_ok    = bus_io.rom1_cs && hit1;
    assign bus_io.rom0_data  = dat0_q;
    assign bus_io.rom1_data  = dat1_q;
    assign bus_io.sdram_addr = addr_q;
    assign bus_io.sdram_cs   = cs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (miss0 || miss1)   state_d = WAIT;
            WAIT: if (bus_io.sdram_ok)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cs   = 1'b0;
        take = 1'b0;
        fire = 1'b0;
        unique case (state_q)
            IDLE: take = miss0 || miss1;
            WAIT: begin
                cs   = 1'b1;
                fire = bus_io.sdram_ok;
            end
            default: ;
        endcase
    end

    // Served port always fills; the other fills too if it wants the same word
    always_comb begin
        sel  = (miss0 && miss1) ? pri_q : miss1;
        upd0 = fire && (!srv_q ||
               (bus_io.rom0_cs && bus_io.rom0_addr == addr_q));
        upd1 = fire && (srv_q ||
               (bus_io.rom1_cs && bus_io.rom1_addr == addr_q));
        addr_d = addr_q;
        srv_d  = srv_q;
        pri_d  = pri_q;
        tag0_d = tag0_q;
        dat0_d = dat0_q;
        vld0_d = vld0_q;
        tag1_d = tag1_q;
        dat1_d = dat1_q;
        vld1_d = vld1_q;
        if (take) begin
            addr_d = sel ? bus_io.rom1_addr : bus_io.rom0_addr;
            srv_d  = sel;
        end
        if (fire) pri_d = ~srv_q;
        if (upd0) begin
            tag0_d = addr_q;
            dat0_d = bus_io.sdram_data;
            vld0_d = 1'b1;
        end
        if (upd1) begin
            tag1_d = addr_q;
            dat1_d = bus_io.sdram_data;
            vld1_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            srv_q  <= 1'b0;
            pri_q  <= 1'b0;
            tag0_q <= '0;
            dat0_q <= '0;
            vld0_q <= 1'b0;
            tag1_q <= '0;
            dat1_q <= '0;
            vld1_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            srv_q  <= srv_d;
            pri_q  <= pri_d;
            tag0_q <= tag0_d;
            dat0_q <= dat0_d;
            vld0_q <= vld0_d;
            tag1_q <= tag1_d;
            dat1_q <= dat1_d;
            vld1_q <= vld1_d;
        end
    end
endmodule

// File: tb/tb_jtoutrun_rdrom_srv.sv
// Bench for jtoutrun_rdrom_srv: directed scenarios, then random
// requests checked against a per-port cache model and an SDRAM image.
module tb_jtoutrun_rdrom_srv;
    logic clk;
    logic rst;
    int   checks = 0;
    int   fails  = 0;

    jtoutrun_rdrom_srv_if #(.AW(14), .DW(16)) ifc ();

    jtoutrun_rdrom_srv #(.AW(14), .DW(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem(input logic [13:0] a);
        logic [31:0] t;
        if (a == 14'h0123) return 16'hA5A5;
        t = {18'd0, a} * 32'd40503 + 32'd7;
        return t[15:0] ^ 16'h3C3C;
    endfunction

    // SDRAM model: answers lat cycles after sdram_cs rises
    int          lat    = 3;
    bit          resp_en = 1'b1;
    logic        resp_ok = 1'b0;
    logic [15:0] resp_data = '0;
    logic        man_ok = 1'b0;
    logic [15:0] man_data = '0;
    int          cnt = 0;
    int          acc = 0;

    assign ifc.sdram_ok   = resp_ok | man_ok;
    assign ifc.sdram_data = man_ok ? man_data : resp_data;

    initial forever begin
        @(negedge clk);
        resp_ok = 1'b0;
        if (!resp_en || !ifc.sdram_cs) cnt = 0;
        else begin
            if (cnt == 0) acc++;
            cnt++;
            if (cnt == lat) begin
                resp_ok   = 1'b1;
                resp_data = mem(ifc.sdram_addr);
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit cond(input int w);
        case (w)
            0: return ifc.rom0_ok;
            1: return ifc.rom1_ok;
            2: return (!ifc.rom0_cs || ifc.rom0_ok) &&
                      (!ifc.rom1_cs || ifc.rom1_ok) && !ifc.sdram_cs;
            default: return !ifc.sdram_cs;
        endcase
    endfunction

    task automatic wait_cond(input string tag, input int w, input int maxc);
        int n = 0;
        while (!cond(w) && n < maxc) begin
            tick;
            n++;
        end
        chk(tag, 32'(cond(w)), 32'd1);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        ifc.rom0_cs = 1'b0;
        ifc.rom1_cs = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    initial begin
        int a0, n, expn;
        bit m0, m1;
        logic [13:0] pool [5];
        bit          mvld [2];
        logic [13:0] mtag [2];

        rst = 1'b1;
        ifc.rom0_cs = 1'b0;
        ifc.rom1_cs = 1'b0;
        ifc.rom0_addr = '0;
        ifc.rom1_addr = '0;
        repeat (3) tick;
        chk("rst_cs",    32'(ifc.sdram_cs),   32'd0);
        chk("rst_addr",  32'(ifc.sdram_addr), 32'd0);
        chk("rst_ok0",   32'(ifc.rom0_ok),    32'd0);
        chk("rst_ok1",   32'(ifc.rom1_ok),    32'd0);
        chk("rst_dat0",  32'(ifc.rom0_data),  32'd0);
        chk("rst_dat1",  32'(ifc.rom1_data),  32'd0);
        ifc.rom0_cs = 1'b1;
        #1;
        chk("rst_ok0_cs", 32'(ifc.rom0_ok), 32'd0);
        ifc.rom0_cs = 1'b0;
        rst = 1'b0;
        tick;

        // single miss, SDRAM answers three cycles after cs
        ifc.rom0_addr = 14'h0123;
        ifc.rom0_cs = 1'b1;
        a0 = acc;
        tick;
        chk("sm_cs",   32'(ifc.sdram_cs),   32'd1);
        chk("sm_addr", 32'(ifc.sdram_addr), 32'h0123);
        chk("sm_ok_e", 32'(ifc.rom0_ok),    32'd0);
        tick;
        tick;
        chk("sm_ok_l", 32'(ifc.rom0_ok),    32'd0);
        tick;
        chk("sm_ok",   32'(ifc.rom0_ok),    32'd1);
        chk("sm_data", 32'(ifc.rom0_data),  32'hA5A5);
        chk("sm_cs_lo", 32'(ifc.sdram_cs),  32'd0);
        tick;
        chk("sm_cs_lo2", 32'(ifc.sdram_cs), 32'd0);
        chk("sm_acc", 32'(acc - a0), 32'd1);

        // hit reuse after cs low
        ifc.rom0_cs = 1'b0;
        repeat (5) tick;
        a0 = acc;
        ifc.rom0_cs = 1'b1;
        #1;
        chk("hit_ok", 32'(ifc.rom0_ok), 32'd1);
        repeat (4) begin
            tick;
            chk("hit_cs", 32'(ifc.sdram_cs), 32'd0);
        end
        chk("hit_acc", 32'(acc - a0), 32'd0);

        // contention after reset: port 0 first
        do_reset;
        ifc.rom0_addr = 14'h0010;
        ifc.rom1_addr = 14'h2000;
        ifc.rom0_cs = 1'b1;
        ifc.rom1_cs = 1'b1;
        a0 = acc;
        tick;
        chk("ct_addr0", 32'(ifc.sdram_addr), 32'h0010);
        wait_cond("ct_wait0", 0, 20);
        chk("ct_ok1_lo", 32'(ifc.rom1_ok),  32'd0);
        chk("ct_gap",    32'(ifc.sdram_cs), 32'd0);
        tick;
        chk("ct_cs2",   32'(ifc.sdram_cs),   32'd1);
        chk("ct_addr1", 32'(ifc.sdram_addr), 32'h2000);
        wait_cond("ct_wait1", 1, 20);
        chk("ct_ok0",  32'(ifc.rom0_ok),   32'd1);
        chk("ct_d0",   32'(ifc.rom0_data), 32'(mem(14'h0010)));
        chk("ct_d1",   32'(ifc.rom1_data), 32'(mem(14'h2000)));
        chk("ct_acc",  32'(acc - a0),      32'd2);

        // shared address
        ifc.rom0_addr = 14'h0456;
        ifc.rom1_addr = 14'h0456;
        a0 = acc;
        n = 0;
        tick;
        while (!ifc.rom0_ok && !ifc.rom1_ok && n < 20) begin
            tick;
            n++;
        end
        chk("sh_same", 32'(ifc.rom0_ok), 32'(ifc.rom1_ok));
        chk("sh_ok",   32'(ifc.rom0_ok), 32'd1);
        tick;
        tick;
        chk("sh_acc",  32'(acc - a0),      32'd1);
        chk("sh_d1",   32'(ifc.rom1_data), 32'(mem(14'h0456)));

        // address change mid-fetch
        do_reset;
        ifc.rom1_addr = 14'h0100;
        ifc.rom1_cs = 1'b1;
        a0 = acc;
        tick;
        ifc.rom1_addr = 14'h0108;
        tick;
        chk("mv_addr", 32'(ifc.sdram_addr), 32'h0100);
        wait_cond("mv_end1", 3, 20);
        chk("mv_ok_lo", 32'(ifc.rom1_ok), 32'd0);
        wait_cond("mv_wait2", 1, 20);
        chk("mv_d1",  32'(ifc.rom1_data), 32'(mem(14'h0108)));
        chk("mv_acc", 32'(acc - a0),      32'd2);

        // reset during WAIT, then a late data pulse
        do_reset;
        resp_en = 1'b0;
        ifc.rom0_addr = 14'h0777;
        ifc.rom0_cs = 1'b1;
        tick;
        tick;
        chk("rw_cs", 32'(ifc.sdram_cs), 32'd1);
        rst = 1'b1;
        ifc.rom0_cs = 1'b0;
        tick;
        chk("rw_cs_rst", 32'(ifc.sdram_cs), 32'd0);
        rst = 1'b0;
        man_data = 16'hBEEF;
        man_ok = 1'b1;
        tick;
        man_ok = 1'b0;
        tick;
        chk("rw_cs_lo", 32'(ifc.sdram_cs), 32'd0);
        chk("rw_ok0",   32'(ifc.rom0_ok),  32'd0);
        chk("rw_ok1",   32'(ifc.rom1_ok),  32'd0);
        ifc.rom0_cs = 1'b1;
        ifc.rom1_cs = 1'b1;
        ifc.rom1_addr = 14'h0000;
        #1;
        chk("rw_inv0", 32'(ifc.rom0_ok), 32'd0);
        chk("rw_inv1", 32'(ifc.rom1_ok), 32'd0);
        chk("rw_dat0", 32'(ifc.rom0_data), 32'd0);
        ifc.rom0_cs = 1'b0;
        ifc.rom1_cs = 1'b0;
        resp_en = 1'b1;
        tick;

        // random requests against the cache model
        pool[0] = 14'h0010;
        pool[1] = 14'h2010;
        pool[2] = 14'h0456;
        pool[3] = 14'h3FFF;
        pool[4] = 14'h0000;
        do_reset;
        mvld[0] = 1'b0;
        mvld[1] = 1'b0;
        mtag[0] = '0;
        mtag[1] = '0;
        for (int i = 0; i < 40; i++) begin
            lat = int'($urandom_range(1, 4));
            tick;
            ifc.rom0_cs   = 1'($urandom_range(0, 1));
            ifc.rom1_cs   = 1'($urandom_range(0, 1));
            ifc.rom0_addr = pool[$urandom_range(0, 4)];
            ifc.rom1_addr = pool[$urandom_range(0, 4)];
            #1;
            m0 = ifc.rom0_cs && !(mvld[0] && mtag[0] == ifc.rom0_addr);
            m1 = ifc.rom1_cs && !(mvld[1] && mtag[1] == ifc.rom1_addr);
            chk("rnd_ok0", 32'(ifc.rom0_ok), 32'(ifc.rom0_cs && !m0));
            chk("rnd_ok1", 32'(ifc.rom1_ok), 32'(ifc.rom1_cs && !m1));
            if (m0 && m1 && ifc.rom0_addr == ifc.rom1_addr) expn = 1;
            else expn = int'(m0) + int'(m1);
            a0 = acc;
            wait_cond("rnd_wait", 2, 40);
            chk("rnd_acc", 32'(acc - a0), 32'(expn));
            if (ifc.rom0_cs) begin
                chk("rnd_d0", 32'(ifc.rom0_data), 32'(mem(ifc.rom0_addr)));
                mvld[0] = 1'b1;
                mtag[0] = ifc.rom0_addr;
            end
            if (ifc.rom1_cs) begin
                chk("rnd_d1", 32'(ifc.rom1_data), 32'(mem(ifc.rom1_addr)));
                mvld[1] = 1'b1;
                mtag[1] = ifc.rom1_addr;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/jtoutrun_rdrom_srv.md
JTOUTRUN_RDROM_SRV -- requirements
Module: jtoutrun_rdrom_srv

Interface
REQ-001 Parameter AW, default 14, ROM word address width shared by both road ports and the SDRAM side.
REQ-002 Parameter DW, default 16, ROM data width (8 pixels at 2 bpp).
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rom0_addr  input  AW  road 0 word address request.
REQ-006 rom0_cs  input  1  road 0 request strobe, level-sensitive.
REQ-007 rom0_data  output  DW  road 0 data, valid while rom0_ok=1.
REQ-008 rom0_ok  output  1  high when rom0_data matches the current rom0_addr.
REQ-009 rom1_addr, rom1_cs, rom1_data, rom1_ok have the same widths and meanings for road 1.
REQ-010 sdram_addr  output  AW  word address issued to SDRAM.
REQ-011 sdram_cs  output  1  SDRAM request; held high until the data pulse arrives.
REQ-012 sdram_data  input  DW  SDRAM read data, valid only during sdram_ok.
REQ-013 sdram_ok  input  1  one-cycle data-valid pulse from SDRAM.

Function
REQ-014 Each port n SHALL hold a registered cache entry: tag_n (AW bits), dat_n (DW bits) and vld_n (1 bit).
REQ-015 hit_n = vld_n and (tag_n == romn_addr); romn_ok = romn_cs and hit_n, combinational; romn_data = dat_n at all times.
REQ-016 miss_n = romn_cs and not hit_n.
REQ-017 The FSM SHALL have 2 states, IDLE and WAIT.
REQ-018 IDLE, no miss: stay in IDLE with sdram_cs=0.
REQ-019 IDLE, miss on one port: on the next edge latch that port's address into sdram_addr, record it as the served port, set sdram_cs=1 and go to WAIT.
REQ-020 IDLE, miss on both ports: serve the port not served last (pri bit); pri resets to port 0 first.
REQ-021 WAIT: hold sdram_addr and sdram_cs constant until sdram_ok=1.
REQ-022 WAIT with sdram_ok=1: on that edge, load tag/dat/vld of the served port with sdram_addr/sdram_data/1, set sdram_cs=0, toggle pri to the other port, go to IDLE.
REQ-023 Shared fetch: on that same edge, also load the other port's entry when its cs=1 and its current addr equals sdram_addr.
REQ-024 Minimum gap: after a completed fetch, sdram_cs SHALL stay low for at least 1 cycle (IDLE evaluation cycle).
REQ-025 Latency: a miss detected at edge k in IDLE raises sdram_cs at edge k+1; sdram_ok at edge m gives romn_ok=1 from edge m (registered update) onward, if the address is unchanged.
REQ-026 Address change during WAIT: the fetch completes with the original address and still updates the cache; ok is then 0 by REQ-015, and the new address is requested on a later IDLE pass.
REQ-027 cs low does not invalidate the cache: a later request to the same address hits with no SDRAM access.
REQ-028 sdram_ok in IDLE SHALL be ignored and SHALL change no state.
REQ-029 Addresses SHALL be compared at the full AW bits, with no truncation.

Reset
REQ-030 While rst=1: state=IDLE, sdram_cs=0, sdram_addr=0, pri=0, vld_0=vld_1=0, tag/dat=0; hence rom0_ok=rom1_ok=0 and romn_data=0.
REQ-031 rst asserted during WAIT SHALL abandon the fetch; a late sdram_ok after reset is ignored per REQ-028.

Verification
REQ-032 Single miss: rom0_cs=1, addr=0x0123; SDRAM returns 0xA5A5 three cycles after sdram_cs -> sdram_addr=0x0123, rom0_ok=1, rom0_data=0xA5A5, sdram_cs low the next cycle.
REQ-033 Hit reuse: repeat 0x0123 after dropping cs for 5 cycles -> rom0_ok=1 with no further sdram_cs assertion.
REQ-034 Contention: both ports miss simultaneously (0x0010, 0x2000) after reset -> port 0 served first, then port 1; both ok end high; the second sdram_cs follows one low cycle.
REQ-035 Shared address: both ports request 0x0456 -> exactly one SDRAM access, and both ok rise on the same cycle.
REQ-036 Address change mid-fetch: rom1 moves from 0x0100 to 0x0108 during WAIT -> rom1_ok stays 0 after the first fetch, then a second fetch of 0x0108 sets rom1_ok=1.
REQ-037 Reset in WAIT: assert rst with sdram_cs=1, then pulse sdram_ok after release -> sdram_cs=0, both ok=0, cache stays invalid.
